// File: rtl/sync_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_filter: per-channel N-flop synchronizer, persistence filter, edge pulses |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module sync_filter #(
    parameter int                 WIDTH      = 1,
    parameter int                 STAGES     = 2,
    parameter logic [WIDTH-1:0]   RST_VAL    = '0,
    parameter int                 FILTER_LEN = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int               CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [STAGES-1:0] stage_q, stage_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              level_q, level_d;
        logic              rise_q, rise_d;
        logic              fall_q, fall_d;
        logic              sync_bit;

        // stage[0] is the LSB; a plain shift keeps the chain free of logic.
        assign sync_bit = stage_q[STAGES-1];

        always_comb begin
            stage_d = {stage_q[STAGES-2:0], async_in[i]};
            cnt_d   = '0;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (sync_bit != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_d = sync_bit;
                    rise_d  = sync_bit;
                    fall_d  = ~sync_bit;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                stage_q <= {STAGES{RST_VAL[i]}};
                cnt_q   <= '0;
                level_q <= RST_VAL[i];
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                stage_q <= stage_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign sync_out[i]   = level_q;
        assign rise_pulse[i] = rise_q;
        assign fall_pulse[i] = fall_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sync_filter: directed scoreboard bench over three sync_filter configs     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sync_filter;

    typedef struct {
        int          cyc;
        int          sel;
        string       tag;
        logic [3:0]  out;
        logic [3:0]  rise;
        logic [3:0]  fall;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a_n, rst_b_n, rst_c_n;
    logic [3:0] in_a, in_c;
    logic [0:0] in_b;
    logic [3:0] out_a, rise_a, fall_a;
    logic [0:0] out_b, rise_b, fall_b;
    logic [3:0] out_c, rise_c, fall_c;

    int    cyc = 0;
    int    base = 0;
    string tname = "reset";
    int    checks = 0;
    int    failures = 0;
    exp_t  exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A: 4 ch, 3 stages, filter 4, reset 0
    sync_filter #(.WIDTH(4), .STAGES(3), .RST_VAL(4'b0000), .FILTER_LEN(4)) dut_a (
        .clk(clk), .n_rst(rst_a_n), .async_in(in_a),
        .sync_out(out_a), .rise_pulse(rise_a), .fall_pulse(fall_a));

    // B: 1 ch, 2 stages, no filtering
    sync_filter #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b0), .FILTER_LEN(1)) dut_b (
        .clk(clk), .n_rst(rst_b_n), .async_in(in_b),
        .sync_out(out_b), .rise_pulse(rise_b), .fall_pulse(fall_b));

    // C: 4 ch, 2 stages, filter 3, reset 1111
    sync_filter #(.WIDTH(4), .STAGES(2), .RST_VAL(4'b1111), .FILTER_LEN(3)) dut_c (
        .clk(clk), .n_rst(rst_c_n), .async_in(in_c),
        .sync_out(out_c), .rise_pulse(rise_c), .fall_pulse(fall_c));

    function automatic logic [11:0] obs(input int sel);
        case (sel)
            0:       return {out_a, rise_a, fall_a};
            1:       return {3'b000, out_b, 3'b000, rise_b, 3'b000, fall_b};
            default: return {out_c, rise_c, fall_c};
        endcase
    endfunction

    // Monitor: pops every expectation due at this cycle and compares.
    always @(negedge clk) begin
        exp_t       e;
        logic [11:0] act;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e   = exp_q.pop_front();
            act = obs(e.sel);
            checks++;
            if (e.cyc != cyc || act != {e.out, e.rise, e.fall}) begin
                failures++;
                $display("FAIL %s dut=%0d cyc=%0d/%0d got out=%b rise=%b fall=%b want out=%b rise=%b fall=%b",
                         e.tag, e.sel, cyc, e.cyc, act[11:8], act[7:4], act[3:0], e.out, e.rise, e.fall);
            end
        end
        checks++;
        if (((rise_a & fall_a) != 4'b0) || ((rise_b & fall_b) != 1'b0) || ((rise_c & fall_c) != 4'b0)) begin
            failures++;
            $display("FAIL pulse_overlap cyc=%0d got a=%b/%b b=%b/%b c=%b/%b want no common bit",
                     cyc, rise_a, fall_a, rise_b, fall_b, rise_c, fall_c);
        end
    end

    task automatic exp_span(input int sel, input int from, input int to,
                            input logic [3:0] o, input logic [3:0] r, input logic [3:0] f);
        for (int k = from; k <= to; k++)
            exp_q.push_back('{cyc: base + k, sel: sel, tag: tname, out: o, rise: r, fall: f});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start(input string name);
        tname = name;
        base  = cyc;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL drain_timeout %s got pending=%0d want 0", tname, exp_q.size());
            $fatal(1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got time=%0t want completion", $time);
        $fatal(1);
    end

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        in_a = 4'b0000; in_b = 1'b0; in_c = 4'b1111;

        start("reset_state");
        for (int k = 1; k <= 2; k++) begin
            exp_span(0, k, k, 4'b0000, 4'b0000, 4'b0000);
            exp_span(1, k, k, 4'b0000, 4'b0000, 4'b0000);
            exp_span(2, k, k, 4'b1111, 4'b0000, 4'b0000);
        end
        tick(2);
        rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;
        drain();

        // Minimal config: latency STAGES+FILTER_LEN = 3.
        tick(1);
        start("b_rise");
        exp_span(1, 1, 2, 4'b0000, 4'b0000, 4'b0000);
        exp_span(1, 3, 3, 4'b0001, 4'b0001, 4'b0000);
        exp_span(1, 4, 5, 4'b0001, 4'b0000, 4'b0000);
        in_b = 1'b1;
        drain();
        tick(1);
        start("b_fall");
        exp_span(1, 1, 2, 4'b0001, 4'b0000, 4'b0000);
        exp_span(1, 3, 3, 4'b0000, 4'b0000, 4'b0001);
        exp_span(1, 4, 5, 4'b0000, 4'b0000, 4'b0000);
        in_b = 1'b0;
        drain();

        // Two channels together, latency 3+4 = 7.
        tick(1);
        start("a_rise_0101");
        exp_span(0, 1, 6, 4'b0000, 4'b0000, 4'b0000);
        exp_span(0, 7, 7, 4'b0101, 4'b0101, 4'b0000);
        exp_span(0, 8, 10, 4'b0101, 4'b0000, 4'b0000);
        in_a = 4'b0101;
        drain();
        tick(1);
        start("a_fall_0101");
        exp_span(0, 1, 6, 4'b0101, 4'b0000, 4'b0000);
        exp_span(0, 7, 7, 4'b0000, 4'b0000, 4'b0101);
        exp_span(0, 8, 10, 4'b0000, 4'b0000, 4'b0000);
        in_a = 4'b0000;
        drain();

        // Three-cycle glitch falls one short of the filter length.
        tick(1);
        start("a_glitch3");
        exp_span(0, 1, 12, 4'b0000, 4'b0000, 4'b0000);
        in_a = 4'b0001;
        tick(3);
        in_a = 4'b0000;
        drain();

        // Four-cycle pulse is accepted, and its trailing edge too, 4 cycles apart.
        tick(1);
        start("a_pulse4");
        exp_span(0, 1, 6, 4'b0000, 4'b0000, 4'b0000);
        exp_span(0, 7, 7, 4'b0001, 4'b0001, 4'b0000);
        exp_span(0, 8, 10, 4'b0001, 4'b0000, 4'b0000);
        exp_span(0, 11, 11, 4'b0000, 4'b0000, 4'b0001);
        exp_span(0, 12, 13, 4'b0000, 4'b0000, 4'b0000);
        in_a = 4'b0001;
        tick(4);
        in_a = 4'b0000;
        drain();

        tick(1);
        start("c_toggle");
        exp_span(2, 1, 56, 4'b1111, 4'b0000, 4'b0000);
        for (int k = 0; k < 50; k++) begin
            in_c = (k % 2 == 0) ? 4'b0000 : 4'b1111;
            tick(1);
        end
        drain();

        // Reset lands mid-count; release with input 0 needs full latency from 1111.
        tick(1);
        start("c_reset_midcount");
        exp_span(2, 1, 5, 4'b1111, 4'b0000, 4'b0000);
        in_c = 4'b0000;
        tick(3);
        rst_c_n = 1'b0;
        tick(2);
        rst_c_n = 1'b1;
        start("c_after_release");
        exp_span(2, 1, 4, 4'b1111, 4'b0000, 4'b0000);
        exp_span(2, 5, 5, 4'b0000, 4'b0000, 4'b1111);
        exp_span(2, 6, 7, 4'b0000, 4'b0000, 4'b0000);
        drain();

        // Reset forces 1111 with no clock edge while the output reads 0000.
        tick(1);
        start("c_reset_async");
        exp_span(2, 1, 2, 4'b0000, 4'b0000, 4'b0000);
        exp_span(2, 3, 12, 4'b1111, 4'b0000, 4'b0000);
        in_c = 4'b1111;
        tick(3);
        rst_c_n = 1'b0;
        tick(2);
        rst_c_n = 1'b1;
        drain();

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_filter.md
SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 Parameter WIDTH, default 1, number of independent input channels (min 1).
REQ-002 Parameter STAGES, default 2, synchronizer flop depth per channel (min 2).
REQ-003 Parameter RST_VAL, default all-zero (WIDTH bits), per-channel reset level of chain, filtered output and edge history.
REQ-004 Parameter FILTER_LEN, default 1, consecutive synchronized cycles a new level must persist before acceptance (min 1; 1 = no filtering).
REQ-005 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Port n_rst  input  1  reset, asynchronous, active-low; one clock, no other reset.
REQ-007 Port async_in  input  WIDTH  asynchronous inputs, bit i = channel i.
REQ-008 Port sync_out  output  WIDTH  synchronized, glitch-filtered level per channel (registered).
REQ-009 Port rise_pulse  output  WIDTH  one-cycle pulse on accepted 0->1 of sync_out (registered).
REQ-010 Port fall_pulse  output  WIDTH  one-cycle pulse on accepted 1->0 of sync_out (registered).

Function
REQ-011 Each channel SHALL be fully independent; no cross-channel logic.
REQ-012 Chain: stage[0] <= async_in[i], stage[k] <= stage[k-1]; s[i] = stage[STAGES-1]; no logic between stages.
REQ-013 Filter per channel: counter cnt, width clog2(FILTER_LEN+1), saturation impossible by construction.
REQ-014 If s[i] == sync_out[i]: cnt <= 0, sync_out holds.
REQ-015 If s[i] != sync_out[i] and cnt < FILTER_LEN-1: cnt <= cnt+1, sync_out holds.
REQ-016 If s[i] != sync_out[i] and cnt == FILTER_LEN-1: sync_out[i] <= s[i], cnt <= 0.
REQ-017 A single cycle of s[i] == sync_out[i] during counting SHALL discard progress (cnt to 0); no partial credit.
REQ-018 rise_pulse[i] SHALL assert in exactly the cycle sync_out[i] first reads 1 after a REQ-016 update, deassert next cycle; fall_pulse likewise for 0.
REQ-019 rise_pulse[i] and fall_pulse[i] SHALL never be high together; each pulse exactly one cycle wide.
REQ-020 Latency: input change stable from before edge 1 SHALL appear on sync_out (and pulse) after edge STAGES+FILTER_LEN-1+1 = STAGES+FILTER_LEN.
REQ-021 Input pulses shorter than FILTER_LEN synchronized cycles SHALL produce no sync_out change and no pulse.
REQ-022 Back-to-back accepted transitions on one channel SHALL each produce their own pulse (minimum spacing FILTER_LEN cycles).
REQ-023 Simultaneous transitions on multiple channels SHALL each be processed with identical latency.
REQ-024 Input toggling every cycle with FILTER_LEN >= 2 SHALL keep sync_out constant indefinitely.

Reset
REQ-025 n_rst low SHALL immediately (no clock) set all stages and sync_out to RST_VAL, all cnt to 0, rise_pulse and fall_pulse to 0.
REQ-026 Reset mid-count SHALL discard pending transitions; no pulse generated by reset or its release.
REQ-027 After release, first accepted change requires full STAGES+FILTER_LEN latency relative to RST_VAL.

Verification
REQ-028 WIDTH=1,STAGES=2,FILTER_LEN=1,RST_VAL=0: async_in 0->1 before edge 1 -> sync_out=1 and rise_pulse=1 after edge 3, rise_pulse=0 after edge 4.
REQ-029 WIDTH=4,STAGES=3,FILTER_LEN=4: async_in=4'b0101 held -> sync_out=0101 after edge 7, rise_pulse=0101 one cycle only; then 4'b0000 -> fall_pulse=0101 after 7 more edges.
REQ-030 FILTER_LEN=4: 3-cycle high glitch on async_in[0] -> sync_out and both pulses stay 0 throughout; 4-cycle high -> one rise_pulse.
REQ-031 FILTER_LEN=3: async_in toggling every cycle for 50 cycles -> sync_out constant, no pulses.
REQ-032 RST_VAL=4'b1111, WIDTH=4: n_rst asserted mid-count with async_in=0 -> sync_out=1111 immediately, no pulses; after release with async_in=0 held, fall_pulse=1111 at full latency.
REQ-033 Random async_in on 8 channels vs cycle-accurate reference model -> exact match of all outputs every cycle; pulses never overlap.
